triangle_scan: RTL and testbench
================================

# triangle_scan

Initiator side of the point-in-triangle query interface. Accepts a triangle (three 11-bit vertices), computes its bounding box, and walks every pixel of the box in row-major order. For each pixel it issues one query to the point-in-triangle tester and streams out the coordinates of pixels reported inside. It sits between the primitive setup stage and the pixel writer, with the tester as its responder.

## Interface
- COORD_W, 11, coordinate width (unsigned)
- SCREEN_W, 640, screen width in pixels (used only with clipping)
- SCREEN_H, 480, screen height in pixels (used only with clipping)
- CNT_W, 2*COORD_W, width of the inside-pixel counter
- clk  in  1  clock; single clock domain, everything on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; vertices sampled when accepted
- p1x, p1y, p2x, p2y, p3x, p3y  in  COORD_W each  triangle vertices
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of scan
- q_start  out  1  one-cycle query pulse to tester
- q_x, q_y  out  COORD_W  query point; held stable from q_start until q_done
- q_done  in  1  tester response strobe
- q_inside  in  1  tester result, valid with q_done
- pix_valid  out  1  inside pixel available
- pix_x, pix_y  out  COORD_W  inside pixel coordinates
- pix_ready  in  1  downstream accepts pixel
- pix_count  out  CNT_W  inside pixels emitted in the current/last scan

## Operation
- FSM states: IDLE, BBOX, ISSUE, WAIT, EMIT, DONE.
- IDLE: when start=1, latch all six vertex coordinates, clear pix_count, go to BBOX.
- BBOX: compute the box. xmin=min(p1x,p2x,p3x), xmax=max(...), and likewise for y. Load cur_x=xmin, cur_y=ymin. Go to ISSUE.
- ISSUE: assert q_start for one cycle with q_x=cur_x, q_y=cur_y. Go to WAIT.
- WAIT: hold q_x/q_y. On q_done: if q_inside=1, go to EMIT; otherwise advance.
- EMIT: pix_valid=1 with pix_x=cur_x, pix_y=cur_y. Outputs are held until pix_ready. On the handshake, pix_count increments and the FSM advances.
- Advance:
  - if cur_x<xmax: cur_x+1, go to ISSUE
  - else if cur_y<ymax: cur_x=xmin, cur_y+1, go to ISSUE
  - else go to DONE
- DONE: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Boundary conditions:
  - start while busy is ignored.
  - q_done outside WAIT is ignored.
  - pix_ready outside EMIT has no effect.
  - Degenerate box (all vertices equal) produces exactly one query.
  - Collinear vertices are scanned normally; the tester decides.
  - Coordinate compares are unsigned. Increments never wrap because cur ≤ max ≤ 2^COORD_W−1.
- Reset (any time, including mid-scan): state IDLE, all outputs 0, pix_count 0, latched vertices 0. An in-flight tester response is discarded.

## Timing
- Start accepted at edge N: BBOX is cycle N+1, first q_start in cycle N+2.
- Per pixel: 1 ISSUE cycle + tester latency (≥1 cycle) + 1 EMIT cycle minimum when inside.
- Advance is taken on the same edge as the q_done/pix handshake.
- busy rises in the cycle after start is sampled. done coincides with the last cycle of busy.
- A new start is accepted in the cycle after done.
- Outputs are registered. q_start and done are exactly one cycle wide.

## Configuration
- SCAN_CLIP_EN defined:
  - BBOX clamps xmax to SCREEN_W−1 and ymax to SCREEN_H−1.
  - If xmin>SCREEN_W−1 or ymin>SCREEN_H−1, the box is empty and BBOX goes directly to DONE: no queries, pix_count=0, done two cycles after start.
- SCAN_CLIP_EN undefined: no clamping; the full COORD_W range is scanned and SCREEN_W/SCREEN_H are unused.

## Structure
- Shared package triangle_pkg:
  - COORD_W default
  - scan state enum
  - packed point struct {x, y}
- Sub-module triangle_bbox: combinational 3-input min/max for x and y, including the clip logic under SCAN_CLIP_EN. Instanced once in the BBOX path.

## Test plan
- Vertices (0,0),(4,0),(0,4), tester model inside iff x+y≤4, ready tied 1 -> 25 queries, 15 pixels emitted in row-major order, pix_count=15, one done pulse.
- All vertices (7,9) -> exactly one query at (7,9). Inside=1 gives one pixel (7,9) and done; inside=0 gives done with pix_count=0.
- Tester latency 3 cycles, pix_ready toggled 1-of-3 -> q_x/q_y and pix_x/pix_y stable while waiting, no pixel lost or duplicated, count matches model.
- start pulsed again during scan of (2,2),(5,2),(2,5) -> second start ignored; single done; result identical to an unperturbed run.
- rst asserted while in WAIT, with a late q_done arriving after release -> outputs 0 immediately, state IDLE, stray q_done produces no pixel. A new start then runs normally.
- SCAN_CLIP_EN, SCREEN_W=640:
  - vertices (700,10),(710,10),(700,20) -> no queries, done at start+2, pix_count=0
  - vertices (630,0),(650,0),(630,2) -> x limited to 630..639, 30 queries

Source files
------------

// File: rtl/triangle_pkg.sv
// Shared types for the triangle scan initiator: coordinate/point types, scan states, screen limits.
// Screen limits only matter when SCAN_CLIP_EN is defined.
package triangle_pkg;
    localparam int COORD_W  = 11;
    localparam int CNT_W    = 2 * COORD_W;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BBOX,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } scan_state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/triangle_scan_if.sv
// Bundle of the setup-stage, tester and pixel-writer signals of triangle_scan.
// master = the scanner itself, slave = its environment (setup, tester, writer).
interface triangle_scan_if;
    import triangle_pkg::*;

    // start is a one-cycle request, sampled only while idle.
    // q_start is a one-cycle pulse; q_x/q_y hold until the tester's q_done strobe (q_inside valid with it).
    // pix_valid/pix_ready: a pixel transfers on any posedge with both high; pix_valid and
    // pix_x/pix_y are held unchanged until that transfer, and pix_ready alone has no effect.
    logic             start;
    coord_t           p1x, p1y, p2x, p2y, p3x, p3y;
    logic             busy;
    logic             done;
    logic             q_start;
    coord_t           q_x, q_y;
    logic             q_done;
    logic             q_inside;
    logic             pix_valid;
    coord_t           pix_x, pix_y;
    logic             pix_ready;
    logic [CNT_W-1:0] pix_count;

    modport master (
        input  start, p1x, p1y, p2x, p2y, p3x, p3y, q_done, q_inside, pix_ready,
        output busy, done, q_start, q_x, q_y, pix_valid, pix_x, pix_y, pix_count
    );

    modport slave (
        output start, p1x, p1y, p2x, p2y, p3x, p3y, q_done, q_inside, pix_ready,
        input  busy, done, q_start, q_x, q_y, pix_valid, pix_x, pix_y, pix_count
    );
endinterface

// File: rtl/triangle_bbox.sv
// Combinational bounding box of three vertices.
// With SCAN_CLIP_EN defined the box is clamped to the screen and flagged empty when fully off-screen.
module triangle_bbox
    import triangle_pkg::*;
(
    input  point_t i_p1,
    input  point_t i_p2,
    input  point_t i_p3,
    output point_t o_min,
    output point_t o_max,
    output logic   o_empty
);
    point_t w_max;

    always_comb begin
        o_min.x = min3(i_p1.x, i_p2.x, i_p3.x);
        o_min.y = min3(i_p1.y, i_p2.y, i_p3.y);
        w_max.x = max3(i_p1.x, i_p2.x, i_p3.x);
        w_max.y = max3(i_p1.y, i_p2.y, i_p3.y);
        o_max   = w_max;
`ifdef SCAN_CLIP_EN
        if (w_max.x > coord_t'(SCREEN_W - 1)) o_max.x = coord_t'(SCREEN_W - 1);
        if (w_max.y > coord_t'(SCREEN_H - 1)) o_max.y = coord_t'(SCREEN_H - 1);
        o_empty = (o_min.x > coord_t'(SCREEN_W - 1)) || (o_min.y > coord_t'(SCREEN_H - 1));
`else
        o_empty = 1'b0;
`endif
    end
endmodule

// File: rtl/triangle_scan.sv
// Walks the bounding box of a triangle in row-major order, queries the point-in-triangle
// tester per pixel and streams inside pixels downstream. Optional screen clipping: SCAN_CLIP_EN.
module triangle_scan
    import triangle_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    triangle_scan_if.master bus,
    output scan_state_t    o_dbg_state
);
    scan_state_t      r_state;
    point_t           r_p1, r_p2, r_p3;
    point_t           r_max, r_cur;
    coord_t           r_xmin;
    logic             r_busy, r_done, r_q_start, r_pix_valid;
    point_t           r_q_pt, r_pix_pt;
    logic [CNT_W-1:0] r_pix_count;

    point_t w_min, w_max, w_next;
    logic   w_empty, w_last_x, w_last_y;

    triangle_bbox u_bbox (
        .i_p1    (r_p1),
        .i_p2    (r_p2),
        .i_p3    (r_p3),
        .o_min   (w_min),
        .o_max   (w_max),
        .o_empty (w_empty)
    );

    // Next raster position; only meaningful while not on the last pixel of the box.
    always_comb begin
        w_last_x = (r_cur.x >= r_max.x);
        w_last_y = (r_cur.y >= r_max.y);
        w_next   = r_cur;
        if (!w_last_x) begin
            w_next.x = r_cur.x + coord_t'(1);
        end else begin
            w_next.x = r_xmin;
            w_next.y = r_cur.y + coord_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_max       <= '0;
            r_cur       <= '0;
            r_xmin      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_q_start   <= 1'b0;
            r_q_pt      <= '0;
            r_pix_valid <= 1'b0;
            r_pix_pt    <= '0;
            r_pix_count <= '0;
        end else begin
            r_q_start <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_p1        <= '{x: bus.p1x, y: bus.p1y};
                        r_p2        <= '{x: bus.p2x, y: bus.p2y};
                        r_p3        <= '{x: bus.p3x, y: bus.p3y};
                        r_pix_count <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_BBOX;
                    end
                end
                S_BBOX: begin
                    r_xmin <= w_min.x;
                    r_max  <= w_max;
                    r_cur  <= w_min;
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_q_start <= 1'b1;
                        r_q_pt    <= w_min;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.q_done) begin
                        if (bus.q_inside) begin
                            r_pix_valid <= 1'b1;
                            r_pix_pt    <= r_cur;
                            r_state     <= S_EMIT;
                        end else if (w_last_x && w_last_y) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur     <= w_next;
                            r_q_pt    <= w_next;
                            r_q_start <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_pix_count <= r_pix_count + CNT_W'(1);
                        if (w_last_x && w_last_y) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur     <= w_next;
                            r_q_pt    <= w_next;
                            r_q_start <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.q_start   = r_q_start;
    assign bus.q_x       = r_q_pt.x;
    assign bus.q_y       = r_q_pt.y;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_x     = r_pix_pt.x;
    assign bus.pix_y     = r_pix_pt.y;
    assign bus.pix_count = r_pix_count;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_triangle_scan.sv
// Bench for triangle_scan: edge-function tester model with variable latency, pixel sink with
// optional backpressure, and a raster reference model of the expected queries and pixels.
`timescale 1ns/1ps
module tb_triangle_scan;
    import triangle_pkg::*;

    typedef logic [2*COORD_W-1:0] pt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    scan_state_t dbg_state;

    triangle_scan_if bus ();

    triangle_scan dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // environment configuration
    int lat        = 1;
    int rdy_mode   = 0;
    int force_mode = 0;
    int vx[3];
    int vy[3];

    // observations
    pt_t got_q[$];
    pt_t q_log[$];
    pt_t exp_q[$];
    pt_t exp_qq[$];
    int  start_k, busy_cyc, first_q_cyc, done_cyc, done_cnt;
    int  done_nobusy, pulse_wide, q_unstable, pix_unstable, stray_q;

    // Point-in-triangle decision using inclusive edge functions (either winding).
    function automatic bit pred(input int x, input int y);
        int e0, e1, e2;
        if (force_mode == 1) return 1'b1;
        if (force_mode == 2) return 1'b0;
        e0 = (vx[1] - vx[0]) * (y - vy[0]) - (vy[1] - vy[0]) * (x - vx[0]);
        e1 = (vx[2] - vx[1]) * (y - vy[1]) - (vy[2] - vy[1]) * (x - vx[1]);
        e2 = (vx[0] - vx[2]) * (y - vy[2]) - (vy[0] - vy[2]) * (x - vx[2]);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    function automatic void build_model();
        int x0, x1, y0, y1;
        exp_q.delete();
        exp_qq.delete();
        x0 = vx[0]; x1 = vx[0]; y0 = vy[0]; y1 = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < x0) x0 = vx[i];
            if (vx[i] > x1) x1 = vx[i];
            if (vy[i] < y0) y0 = vy[i];
            if (vy[i] > y1) y1 = vy[i];
        end
`ifdef SCAN_CLIP_EN
        if (x0 > SCREEN_W - 1 || y0 > SCREEN_H - 1) return;
        if (x1 > SCREEN_W - 1) x1 = SCREEN_W - 1;
        if (y1 > SCREEN_H - 1) y1 = SCREEN_H - 1;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                exp_qq.push_back({COORD_W'(x), COORD_W'(y)});
                if (pred(x, y)) exp_q.push_back({COORD_W'(x), COORD_W'(y)});
            end
    endfunction

    function automatic int first_diff(input pt_t a[$], input pt_t b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : n;
    endfunction

    // Tester responder: answers each q_start after 'lat' cycles and watches the held query point.
    initial begin
        int  pending;
        pt_t tpt;
        pending = 0;
        tpt = '0;
        bus.q_done = 1'b0;
        bus.q_inside = 1'b0;
        forever begin
            @(negedge clk);
            bus.q_done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (dbg_state == S_WAIT && ({bus.q_x, bus.q_y} !== tpt || bus.q_start)) q_unstable++;
                if (pending == 0) begin
                    bus.q_done = 1'b1;
                    bus.q_inside = pred(int'(tpt[2*COORD_W-1:COORD_W]), int'(tpt[COORD_W-1:0]));
                    if (dbg_state == S_IDLE) stray_q++;
                end
            end else if (bus.q_start) begin
                tpt = {bus.q_x, bus.q_y};
                q_log.push_back(tpt);
                if (first_q_cyc < 0) first_q_cyc = cyc;
                pending = lat;
            end
        end
    end

    // Pixel sink with optional 1-in-3 ready pattern.
    initial begin
        int  rdy_cnt;
        bit  r, prev_wait;
        pt_t prev_pix;
        rdy_cnt = 0;
        prev_wait = 1'b0;
        prev_pix = '0;
        bus.pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            rdy_cnt++;
            r = (rdy_mode == 0) ? 1'b1 : (rdy_cnt % 3 == 0);
            bus.pix_ready = r;
            if (rst) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && bus.pix_valid && {bus.pix_x, bus.pix_y} !== prev_pix) pix_unstable++;
                if (bus.pix_valid && r) got_q.push_back({bus.pix_x, bus.pix_y});
                prev_wait = bus.pix_valid && !r;
                prev_pix = {bus.pix_x, bus.pix_y};
            end
        end
    end

    // Pulse and busy monitor.
    initial begin
        bit prev_done, prev_qs;
        prev_done = 1'b0;
        prev_qs = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!bus.busy) done_nobusy++;
                if (prev_done) pulse_wide++;
            end
            if (bus.q_start && prev_qs) pulse_wide++;
            if (bus.busy && busy_cyc < 0) busy_cyc = cyc;
            prev_done = bus.done;
            prev_qs = bus.q_start;
        end
    end

    task automatic launch(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
        vx[0] = ax; vy[0] = ay; vx[1] = bx; vy[1] = by; vx[2] = cx; vy[2] = cy;
        bus.p1x = COORD_W'(ax); bus.p1y = COORD_W'(ay);
        bus.p2x = COORD_W'(bx); bus.p2y = COORD_W'(by);
        bus.p3x = COORD_W'(cx); bus.p3y = COORD_W'(cy);
        build_model();
        @(negedge clk);
        got_q.delete();
        q_log.delete();
        done_cnt = 0; busy_cyc = -1; first_q_cyc = -1; done_cyc = -1;
        done_nobusy = 0; pulse_wide = 0; q_unstable = 0; pix_unstable = 0;
        bus.start = 1'b1;
        start_k = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.q_start, bus.q_x, bus.q_y, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_count} !== '0
            || dbg_state !== S_IDLE)
            $display("FAIL reset_outputs: got busy=%b q_start=%b pix_valid=%b count=%0d state=%0d, expected all 0 / IDLE",
                     bus.busy, bus.q_start, bus.pix_valid, bus.pix_count, dbg_state);
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_triangle();
        bit seen;
        lat = 1; rdy_mode = 0; force_mode = 0;
        launch(0, 0, 4, 0, 0, 4);
        wait_done(seen);
        n_checks++;
        if (!seen) $display("FAIL basic_done: got no done pulse, expected one"); else n_pass++;
        n_checks++;
        if (q_log.size() != 25 || first_diff(q_log, exp_qq) != -1)
            $display("FAIL basic_queries: got %0d queries, expected 25 in row-major order", q_log.size());
        else n_pass++;
        n_checks++;
        if (got_q.size() != 15 || first_diff(got_q, exp_q) != -1)
            $display("FAIL basic_pixels: got %0d pixels, expected 15 (x+y<=4) in order", got_q.size());
        else n_pass++;
        n_checks++;
        if (bus.pix_count !== CNT_W'(15)) $display("FAIL basic_count: got %0d expected 15", bus.pix_count); else n_pass++;
        n_checks++;
        if (busy_cyc != start_k + 1 || first_q_cyc != start_k + 2)
            $display("FAIL basic_timing: got busy@+%0d q_start@+%0d, expected +1 and +2",
                     busy_cyc - start_k, first_q_cyc - start_k);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || done_nobusy != 0 || pulse_wide != 0)
            $display("FAIL basic_pulses: got done_cnt=%0d done_without_busy=%0d wide_pulses=%0d, expected 1/0/0",
                     done_cnt, done_nobusy, pulse_wide);
        else n_pass++;
    endtask

    task automatic test_degenerate();
        bit seen;
        lat = 1; rdy_mode = 0;
        for (int f = 1; f <= 2; f++) begin
            force_mode = f;
            launch(7, 9, 7, 9, 7, 9);
            wait_done(seen);
            n_checks++;
            if (!seen || q_log.size() != 1 || q_log[0] !== {COORD_W'(7), COORD_W'(9)})
                $display("FAIL degenerate_query[%0d]: got done=%b queries=%0d, expected one query at (7,9)",
                         f, seen, q_log.size());
            else n_pass++;
            n_checks++;
            if (first_diff(got_q, exp_q) != -1 || bus.pix_count !== CNT_W'(f == 1 ? 1 : 0))
                $display("FAIL degenerate_pixels[%0d]: got %0d pixels count=%0d, expected %0d",
                         f, got_q.size(), bus.pix_count, (f == 1) ? 1 : 0);
            else n_pass++;
        end
        force_mode = 0;
    endtask

    task automatic test_backpressure();
        bit seen;
        lat = 3; rdy_mode = 1; force_mode = 0;
        launch(1, 1, 6, 2, 3, 7);
        wait_done(seen);
        n_checks++;
        if (!seen) $display("FAIL bp_done: got no done pulse, expected one"); else n_pass++;
        n_checks++;
        if (q_unstable != 0 || pix_unstable != 0)
            $display("FAIL bp_stable: got %0d query and %0d pixel changes while waiting, expected 0",
                     q_unstable, pix_unstable);
        else n_pass++;
        n_checks++;
        if (first_diff(got_q, exp_q) != -1 || bus.pix_count !== CNT_W'(exp_q.size()))
            $display("FAIL bp_pixels: got %0d pixels count=%0d, expected %0d",
                     got_q.size(), bus.pix_count, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_start_during_scan();
        bit seen;
        lat = 1; rdy_mode = 0; force_mode = 0;
        launch(2, 2, 5, 2, 2, 5);
        repeat (10) @(negedge clk);
        bus.p1x = COORD_W'(100); bus.p1y = COORD_W'(200); bus.p2x = COORD_W'(300);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!seen || done_cnt != 1 || bus.busy)
            $display("FAIL restart_done: got done_cnt=%0d busy=%b, expected 1 done and idle", done_cnt, bus.busy);
        else n_pass++;
        n_checks++;
        if (first_diff(q_log, exp_qq) != -1 || first_diff(got_q, exp_q) != -1 || bus.pix_count !== CNT_W'(exp_q.size()))
            $display("FAIL restart_result: got %0d queries %0d pixels, expected %0d queries %0d pixels",
                     q_log.size(), got_q.size(), exp_qq.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        int guard;
        lat = 6; rdy_mode = 0; force_mode = 0;
        launch(0, 0, 8, 0, 0, 8);
        guard = 0;
        while (dbg_state != S_WAIT && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (dbg_state != S_WAIT) $display("FAIL rst_reach_wait: got state %0d, expected WAIT", dbg_state); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.q_start, bus.q_x, bus.q_y, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_count} !== '0
            || dbg_state !== S_IDLE)
            $display("FAIL rst_async: got busy=%b q_x=%0d q_y=%0d state=%0d, expected all 0 / IDLE",
                     bus.busy, bus.q_x, bus.q_y, dbg_state);
        else n_pass++;
        stray_q = 0;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        repeat (10) @(negedge clk);
        n_checks++;
        if (stray_q == 0 || got_q.size() != 0 || dbg_state !== S_IDLE || bus.busy || bus.pix_count !== '0)
            $display("FAIL rst_stray: got stray=%0d pixels=%0d state=%0d busy=%b, expected late q_done ignored in IDLE",
                     stray_q, got_q.size(), dbg_state, bus.busy);
        else n_pass++;
        lat = 1;
        launch(2, 1, 6, 3, 1, 5);
        wait_done(seen);
        n_checks++;
        if (!seen || first_diff(got_q, exp_q) != -1 || bus.pix_count !== CNT_W'(exp_q.size()))
            $display("FAIL rst_rerun: got done=%b %0d pixels, expected %0d", seen, got_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit seen;
        int bx, by;
        for (int it = 0; it < 8; it++) begin
            lat = $urandom_range(1, 3);
            rdy_mode = $urandom_range(0, 1);
            force_mode = 0;
            bx = $urandom_range(0, 2038);
            by = $urandom_range(0, 2038);
            launch(bx + $urandom_range(0, 8), by + $urandom_range(0, 8), bx + $urandom_range(0, 8),
                   by + $urandom_range(0, 8), bx + $urandom_range(0, 8), by + $urandom_range(0, 8));
            wait_done(seen);
            n_checks++;
            if (!seen || first_diff(q_log, exp_qq) != -1)
                $display("FAIL random_queries[%0d]: got done=%b %0d queries, expected %0d", it, seen, q_log.size(), exp_qq.size());
            else n_pass++;
            n_checks++;
            if (first_diff(got_q, exp_q) != -1 || bus.pix_count !== CNT_W'(exp_q.size()))
                $display("FAIL random_pixels[%0d]: got %0d pixels count=%0d, expected %0d",
                         it, got_q.size(), bus.pix_count, exp_q.size());
            else n_pass++;
        end
    endtask

`ifdef SCAN_CLIP_EN
    task automatic test_clip();
        bit seen;
        lat = 1; rdy_mode = 0; force_mode = 1;
        launch(700, 10, 710, 10, 700, 20);
        wait_done(seen);
        n_checks++;
        if (!seen || q_log.size() != 0 || done_cyc != start_k + 2 || bus.pix_count !== '0)
            $display("FAIL clip_empty: got %0d queries done@+%0d count=%0d, expected 0 queries done@+2 count 0",
                     q_log.size(), done_cyc - start_k, bus.pix_count);
        else n_pass++;
        launch(630, 0, 650, 0, 630, 2);
        wait_done(seen);
        n_checks++;
        if (!seen || q_log.size() != 30 || first_diff(q_log, exp_qq) != -1)
            $display("FAIL clip_edge: got %0d queries, expected 30 over x 630..639", q_log.size());
        else n_pass++;
        force_mode = 0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.p1x = '0; bus.p1y = '0; bus.p2x = '0; bus.p2y = '0; bus.p3x = '0; bus.p3y = '0;
        test_reset();
        test_basic_triangle();
        test_degenerate();
        test_backpressure();
        test_start_during_scan();
        test_reset_mid_scan();
        test_random();
`ifdef SCAN_CLIP_EN
        test_clip();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
